// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared state encodings and width helper for the tristate bus arbiter.
package tristate_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    TURN  = ST_TURN
  } state_t;

  // Ceiling log2, floored at 1 so a width derived from it is never zero.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between the bus arbiter and its tristate drivers.
interface tristate_bus_arbiter_if
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  localparam int GW = clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] en;
  logic [GW-1:0]    grant_id;
  logic             busy;

  modport master (input req, output en, grant_id, busy);
  modport slave  (output req, input en, grant_id, busy);

endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last, wrapping modulo N_REQ.
module rr_pick
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    winner,
  output logic             any_req
);

  logic [GW:0]   sum_w [N_REQ];
  logic [GW-1:0] cand  [N_REQ];

  // cand[gi] is the requester at distance gi+1 from last; explicit wrap handles non-power-of-two N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign sum_w[gi] = {1'b0, last} + (GW+1)'(gi + 1);
    assign cand[gi]  = (sum_w[gi] >= (GW+1)'(N_REQ)) ? GW'(sum_w[gi] - (GW+1)'(N_REQ))
                                                     : sum_w[gi][GW-1:0];
  end

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        winner  = cand[i];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter driving one-hot tristate enables with a one-cycle turnaround between grants.
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tristate_bus_arbiter_if.master bus
);

  localparam int GW = clog2(N_REQ);
  localparam int HW = clog2(MAX_HOLD + 1);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] en_reg, en_next;
  logic [GW-1:0]    grant_id_reg, grant_id_next;
  logic [GW-1:0]    last_reg, last_next;
  logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
  logic             busy_reg, busy_next;
  logic [GW-1:0]    winner;
  logic             any_req;

  rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req     (bus.req),
    .last    (last_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      en_reg       <= '0;
      grant_id_reg <= '0;
      last_reg     <= GW'(N_REQ - 1);
      hold_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      en_reg       <= en_next;
      grant_id_reg <= grant_id_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    en_next       = '0;
    grant_id_next = grant_id_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE, TURN: begin
        // TURN and IDLE differ only in that en was just dropped; both grant on any request.
        if (any_req) begin
          state_next       = GRANT;
          en_next[winner]  = 1'b1;
          grant_id_next    = winner;
          hold_cnt_next    = HW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[grant_id_reg] || hold_cnt_reg == HW'(MAX_HOLD)) begin
          state_next = TURN;
          last_next  = grant_id_reg;
        end else begin
          en_next[grant_id_reg] = 1'b1;
          hold_cnt_next         = hold_cnt_reg + HW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next == GRANT);
  end

  assign bus.en       = en_reg;
  assign bus.grant_id = grant_id_reg;
  assign bus.busy     = busy_reg;

endmodule
